// File: rtl/looper_pkg.sv
// Shared definitions for the multi-track looper.
// The four looper modes and their fixed 2-bit encoding.
package looper_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REC  = 2'b01,
      PLAY = 2'b10,
      ODUB = 2'b11
   } looper_state_e;

endpackage

// File: rtl/loop_addr_ctr.sv
// Per-track sample address counter.
// clr returns to 0 and takes priority over counting. tick_en advances by one.
// The count wraps to 0 after reaching limit-1.
// at_last flags that the current address is limit-1.
module loop_addr_ctr #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              tick_en,
   input  logic [ADDR_W:0]   limit,
   output logic [ADDR_W-1:0] addr,
   output logic              at_last
);

   assign at_last = ({1'b0, addr} == (limit - (ADDR_W+1)'(1)));

   // Address register: clear, advance on tick, wrap at the loop boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (clr) begin
         addr <= '0;
      end else if (tick_en) begin
         addr <= at_last ? '0 : addr + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/multi_track_looper.sv
// Multi-track audio looper controller: record/play/overdub sequencing,
// master loop length and per-track content flags.
// Optional feature macro: LOOPER_OVERDUB_EN (rec_btn in PLAY enters overdub;
// when undefined, rec_btn in PLAY re-records the selected track from address 0).
//
// state | meaning
// IDLE  | stopped, address parked at 0, accepts clear
// REC   | writing samples; first take sets the master loop length
// PLAY  | reading samples around the loop
// ODUB  | reading and writing the same address around the loop
module multi_track_looper
   import looper_pkg::*;
#(
   parameter int  NUM_TRACKS = 4,
   parameter int  ADDR_W     = 16,
   localparam int TW         = $clog2(NUM_TRACKS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rec_btn,
   input  logic                  play_btn,
   input  logic                  clear_btn,
   input  logic [TW-1:0]         track_sel,
   input  logic                  sample_tick,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_wr_en,
   output logic                  mem_rd_en,
   output logic [TW-1:0]         active_track,
   output logic [ADDR_W:0]       loop_len,
   output logic [NUM_TRACKS-1:0] loop_valid,
   output logic                  led_rec,
   output logic                  led_play,
   output logic                  led_odub
);

   localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

   looper_state_e         state, state_nx;
   logic [ADDR_W:0]       len_nx, ctr_limit, rec_count;
   logic [NUM_TRACKS-1:0] valid_nx;
   logic [TW-1:0]         track_nx;
   logic                  addr_clr, tick_en, at_last, first_take;

   assign first_take = (loop_len == '0);
   assign tick_en    = sample_tick & (state != IDLE);
   // The first take may run to the full address space; later takes follow the master length.
   assign ctr_limit  = (state == REC && first_take) ? FULL_LEN : loop_len;
   // Samples written so far, including a tick landing in this cycle.
   assign rec_count  = {1'b0, mem_addr} + {{ADDR_W{1'b0}}, sample_tick};

   assign mem_wr_en = sample_tick & ((state == REC) | (state == ODUB));
   assign mem_rd_en = sample_tick & ((state == PLAY) | (state == ODUB));
   assign led_rec   = (state == REC);
   assign led_play  = (state == PLAY);
`ifdef LOOPER_OVERDUB_EN
   assign led_odub  = (state == ODUB);
`else
   assign led_odub  = 1'b0;
`endif

   loop_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (addr_clr),
      .tick_en (tick_en),
      .limit   (ctr_limit),
      .addr    (mem_addr),
      .at_last (at_last)
   );

   // Command decode and next-state selection; clear only acts while stopped.
   always_comb begin
      state_nx = state;
      len_nx   = loop_len;
      valid_nx = loop_valid;
      track_nx = active_track;
      addr_clr = 1'b0;
      case (state)
         IDLE: begin
            if (clear_btn) begin
               valid_nx = '0;
               len_nx   = '0;
            end else if (rec_btn) begin
               state_nx = REC;
               track_nx = track_sel;
               addr_clr = 1'b1;
            end else if (play_btn && loop_valid != '0) begin
               state_nx = PLAY;
               addr_clr = 1'b1;
            end
         end
         REC: begin
            if (rec_btn || play_btn) begin
               if (rec_count == '0) begin
                  state_nx = IDLE;
                  addr_clr = 1'b1;
               end else begin
                  state_nx               = PLAY;
                  valid_nx[active_track] = 1'b1;
                  if (first_take) begin
                     len_nx   = rec_count;
                     addr_clr = 1'b1;
                  end
               end
            end else if (sample_tick && at_last) begin
               state_nx               = PLAY;
               valid_nx[active_track] = 1'b1;
               if (first_take) len_nx = FULL_LEN;
            end
         end
         PLAY: begin
            if (rec_btn) begin
`ifdef LOOPER_OVERDUB_EN
               state_nx            = ODUB;
               track_nx            = track_sel;
               valid_nx[track_sel] = 1'b1;
`else
               state_nx = REC;
               track_nx = track_sel;
               addr_clr = 1'b1;
`endif
            end else if (play_btn) begin
               state_nx = IDLE;
               addr_clr = 1'b1;
            end
         end
         ODUB: begin
            if (rec_btn) begin
               state_nx = PLAY;
            end else if (play_btn) begin
               state_nx = IDLE;
               addr_clr = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Control registers; reset drops all recorded-loop bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         loop_len     <= '0;
         loop_valid   <= '0;
         active_track <= '0;
      end else begin
         state        <= state_nx;
         loop_len     <= len_nx;
         loop_valid   <= valid_nx;
         active_track <= track_nx;
      end
   end

endmodule
